pe_reg_pipe: RTL and testbench
==============================

PE_REG_PIPE -- requirements
Module: pe_reg_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  global advance enable; low freezes the pipe.
REQ-006 flush  input  1  synchronous clear of all stage valid bits.
REQ-007 in_valid  input  1  upstream data valid.
REQ-008 in_ready  output  1  pipe accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  upstream data.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  WIDTH  data of last stage (DEPTH-1).
REQ-013 count  output  $clog2(DEPTH+1)  occupied stages; present only with PE_REG_COUNT_EN.

Function
REQ-014 Each stage i (0..DEPTH-1) SHALL hold data[i] (WIDTH bits) and valid[i] (1 bit); stage 0 is input side, stage DEPTH-1 drives out_data/out_valid.
REQ-015 out_valid SHALL equal valid[DEPTH-1] AND en AND NOT flush; out_data SHALL equal data[DEPTH-1] (combinational from registers).
REQ-016 Output transfer SHALL occur when out_valid AND out_ready.
REQ-017 Stage DEPTH-1 SHALL be free when NOT valid[DEPTH-1] or output transfer; stage i<DEPTH-1 SHALL be free when NOT valid[i] or stage i moves into i+1.
REQ-018 Stage i valid SHALL move to stage i+1 when en AND NOT flush AND stage i+1 free (bubble-collapsing; empty stages never stall upstream).
REQ-019 in_ready SHALL equal en AND NOT flush AND stage 0 free; input transfer when in_valid AND in_ready loads in_data into stage 0 and sets valid[0].
REQ-020 A stage neither loaded nor emptied SHALL hold data and valid unchanged.
REQ-021 Latency into an empty pipe with en=1, out_ready=1, no flush: data accepted at edge t SHALL present on out_data/out_valid after edge t+DEPTH-1 (DEPTH cycles accept-to-transfer).
REQ-022 Throughput: with en=1, out_ready=1, no flush, the pipe SHALL accept and deliver one word per cycle.
REQ-023 Full pipe with out_ready=1 SHALL accept a new word in the same cycle as emitting one (simultaneous in/out on full).
REQ-024 en=0: in_ready=0, out_valid=0, no stage changes; on en returning high contents SHALL resume in order, none lost or duplicated.
REQ-025 flush=1 at an edge SHALL clear every valid bit; flush overrides en and all transfers; data registers MAY retain stale values.
REQ-026 Data order SHALL be strictly preserved (FIFO order).
REQ-027 in_data SHALL be ignored when no input transfer occurs; out_ready SHALL be ignored when out_valid=0.

Reset
REQ-028 reset low SHALL immediately and asynchronously clear all valid bits and all data registers to 0.
REQ-029 During reset: in_ready=0, out_valid=0, out_data=0, count=0.
REQ-030 Reset asserted mid-operation SHALL discard all held words; first cycle after release SHALL show an empty pipe with in_ready=en.

Configuration
REQ-031 Macro PE_REG_COUNT_EN defined: count port SHALL exist, equal to number of set valid bits, updated at each edge (+1 on input only, -1 on output only, unchanged on both/neither, 0 on flush/reset).
REQ-032 PE_REG_COUNT_EN undefined: count port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 DEPTH=2, WIDTH=32, en=1, out_ready=1: send 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on consecutive cycles, first one cycle after 0x1 accepted... i.e. 2 cycles from acceptance to transfer, in_ready constantly 1.
REQ-034 DEPTH=3, out_ready=0, stream 0xA..0xD -> 0xA,0xB,0xC accepted, in_ready=0 after third, count=3; raise out_ready -> 0xA emitted and 0xD accepted in same cycle.
REQ-035 DEPTH=2, one word 0x55 then en=0 for 5 cycles -> in_ready=0, out_valid=0, contents frozen; en=1 -> 0x55 emitted once.
REQ-036 DEPTH=4 holding 3 words, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, flushed input not captured.
REQ-037 DEPTH=2, pipe full, reset pulsed low between edges -> out_valid and out_data 0 immediately; after release stream 0x7 -> 0x7 emitted after 2 cycles.
REQ-038 Build with and without PE_REG_COUNT_EN at DEPTH=1 and DEPTH=4 -> identical data/handshake traces; count matches reference model when present.

Source files
------------

// File: rtl/pe_reg_pipe.sv
// ---------------------------------------------------------------------------
// pe_reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse.
// Each stage holds one word plus a valid bit. Words advance toward the output
// whenever the next stage is free, so empty stages never stall upstream.
//
// Optional feature macro: PE_REG_COUNT_EN (adds the occupancy port 'count').
//
// Parameters:
//   WIDTH      data width in bits (>=1)
//   DEPTH      number of register stages (>=1)
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset (clears valid and data)
//   en         global advance enable; low freezes the pipe
//   flush      synchronous clear of all valid bits, overrides en
//   in_valid   upstream word valid
//   in_ready   pipe accepts in_data this cycle
//   in_data    upstream word
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   out_data   word held in the last stage
//   count      number of occupied stages (PE_REG_COUNT_EN only)
// ---------------------------------------------------------------------------
module pe_reg_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PE_REG_COUNT_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];

   // move_c[i]: stage i hands its word on this cycle (to stage i+1, or out)
   logic [DEPTH-1:0] move_c;
   logic             adv_c;
   logic             in_free_c;
   logic             in_xfer_c;

   // Free/move chain resolved from the output side back toward the input
   always_comb begin : handshake
      logic ok;
      adv_c  = en & ~flush;
      move_c = '0;
      ok     = out_ready;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         move_c[i] = valid_q[i] & adv_c & ok;
         ok        = ~valid_q[i] | move_c[i];
      end
      in_free_c = ok;
   end

   // reset gating keeps in_ready low while the pipe is held in reset
   assign in_ready  = reset & adv_c & in_free_c;
   assign in_xfer_c = in_valid & in_ready;
   assign out_valid = valid_q[DEPTH-1] & adv_c;
   assign out_data  = data_q[DEPTH-1];

   // Each stage loads from its upstream neighbour (or in_data), else holds
   always_comb begin : next_state
      logic             inc;
      logic [WIDTH-1:0] src;
      valid_d = '0;
      data_d  = data_q;
      inc     = in_xfer_c;
      src     = in_data;
      for (int i = 0; i < int'(DEPTH); i++) begin
         valid_d[i] = ~flush & (inc | (valid_q[i] & ~move_c[i]));
         data_d[i]  = inc ? src : data_q[i];
         inc        = move_c[i];
         src        = data_q[i];
      end
   end

   // Stage registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

`ifdef PE_REG_COUNT_EN
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             out_xfer_c;

   assign out_xfer_c = move_c[DEPTH-1];

   // Occupancy tracks accepted minus emitted words
   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (in_xfer_c && !out_xfer_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (!in_xfer_c && out_xfer_c) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
`endif

endmodule

// File: tb/tb_pe_reg_pipe.sv
// ---------------------------------------------------------------------------
// tb_pe_reg_pipe: scoreboard bench for pe_reg_pipe at DEPTH=3, WIDTH=32.
// Accepted words are queued with their accept cycle; emitted words are popped
// and compared in order. Occupancy (when present) must equal the queue size.
// ---------------------------------------------------------------------------
module tb_pe_reg_pipe;

   localparam int unsigned W  = 32;
   localparam int unsigned D  = 3;
   localparam int unsigned CW = $clog2(D+1);

   typedef struct {
      logic [W-1:0] d;
      int           c;
   } ent_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
`ifdef PE_REG_COUNT_EN
   logic [CW-1:0] count;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_out, lat_min, lat_max, first_out, last_out;
   ent_t sb[$];

   always #5 clk = ~clk;

   pe_reg_pipe #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef PE_REG_COUNT_EN
      ,
      .count     (count)
`endif
   );

   task automatic drive(input logic e, input logic fl, input logic iv,
                        input logic [W-1:0] d, input logic ordy);
      en        = e;
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
   endtask

   task automatic clear_stats();
      n_out   = 0;
      lat_min = 1000;
      lat_max = 0;
      first_out = 0;
      last_out  = 0;
   endtask

   // One clock: sample at negedge, update scoreboard, advance past posedge
   task automatic tick();
      ent_t e;
      int   lat;
      @(negedge clk);
`ifdef PE_REG_COUNT_EN
      n_tests++;
      if (count !== CW'(sb.size())) begin
         n_fail++;
         $display("FAIL count: got %0d expected %0d (cycle %0d)", count, sb.size(), cyc);
      end
`endif
      if (out_valid && out_ready) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out: got %h expected no output (cycle %0d)", out_data, cyc);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.d) begin
               n_fail++;
               $display("FAIL out_data: got %h expected %h (cycle %0d)", out_data, e.d, cyc);
            end
            lat = cyc - e.c;
            if (lat < lat_min) lat_min = lat;
            if (lat > lat_max) lat_max = lat;
            if (n_out == 0) first_out = cyc;
            last_out = cyc;
            n_out++;
         end
      end
      if (in_valid && in_ready) sb.push_back('{in_data, cyc});
      if (flush) sb.delete();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(input string name);
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d words left expected 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      #2;
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b ov=%b od=%h expected 0 0 0",
                  in_ready, out_valid, out_data);
      end
`ifdef PE_REG_COUNT_EN
      n_tests++;
      if (count !== '0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d expected 0", count);
      end
`endif
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset: got rdy=%b ov=%b expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_stream();
      clear_stats();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, W'(i + 1), 1'b1);
         #1;
         n_tests++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_in_ready: got %b expected 1 (word %0d)", in_ready, i);
         end
         tick();
      end
      drain("stream");
      n_tests++;
      if (n_out != 3 || lat_min != int'(D) || lat_max != int'(D)) begin
         n_fail++;
         $display("FAIL stream_latency: got n=%0d lat %0d..%0d expected n=3 lat %0d",
                  n_out, lat_min, lat_max, D);
      end
      n_tests++;
      if (last_out - first_out != 2) begin
         n_fail++;
         $display("FAIL stream_back_to_back: got span %0d expected 2", last_out - first_out);
      end
   endtask

   task automatic test_backpressure();
      int n0;
      for (int i = 0; i < int'(D); i++) begin
         drive(1'b1, 1'b0, 1'b1, W'(32'hA + i), 1'b0);
         #1;
         n_tests++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_fill_ready: got %b expected 1 (word %0d)", in_ready, i);
         end
         tick();
      end
      drive(1'b1, 1'b0, 1'b1, W'(32'hD), 1'b0);
      #1;
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== W'(32'hA)) begin
         n_fail++;
         $display("FAIL bp_full: got rdy=%b ov=%b od=%h expected 0 1 0000000a",
                  in_ready, out_valid, out_data);
      end
      tick();
      drive(1'b1, 1'b0, 1'b1, W'(32'hD), 1'b1);
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_simultaneous: got rdy=%b ov=%b expected 1 1", in_ready, out_valid);
      end
      n0 = n_out;
      tick();
      n_tests++;
      if (n_out != n0 + 1) begin
         n_fail++;
         $display("FAIL bp_emit: got %0d outputs expected 1", n_out - n0);
      end
      drain("bp");
   endtask

   task automatic test_freeze();
      int n0;
      drive(1'b1, 1'b0, 1'b1, W'(32'h55), 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, W'(32'h99), 1'b1);
         #1;
         n_tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze: got rdy=%b ov=%b expected 0 0 (cycle %0d)",
                     in_ready, out_valid, i);
         end
         tick();
      end
      n0 = n_out;
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 8; i++) tick();
      n_tests++;
      if (n_out - n0 != 1) begin
         n_fail++;
         $display("FAIL freeze_resume: got %0d outputs expected 1", n_out - n0);
      end
   endtask

   task automatic test_flush();
      int n0;
      for (int i = 0; i < int'(D) - 1; i++) begin
         drive(1'b1, 1'b0, 1'b1, W'(32'h100 + i), 1'b0);
         tick();
      end
      drive(1'b1, 1'b1, 1'b1, W'(32'hDEAD), 1'b1);
      #1;
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_cycle: got rdy=%b ov=%b expected 0 0", in_ready, out_valid);
      end
      tick();
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_flush: got ov=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
      n0 = n_out;
      for (int i = 0; i < 6; i++) tick();
      n_tests++;
      if (n_out != n0) begin
         n_fail++;
         $display("FAIL flush_leak: got %0d outputs expected 0", n_out - n0);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < int'(D); i++) begin
         drive(1'b1, 1'b0, 1'b1, W'(32'h200 + i), 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      #1;
      n_tests++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_full: got ov=%b expected 1", out_valid);
      end
      #1;
      reset = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_async: got ov=%b od=%h rdy=%b expected 0 0 0",
                  out_valid, out_data, in_ready);
      end
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      clear_stats();
      drive(1'b1, 1'b0, 1'b1, W'(32'h7), 1'b1);
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_empty: got rdy=%b ov=%b expected 1 0", in_ready, out_valid);
      end
      tick();
      drain("rstmid");
      n_tests++;
      if (n_out != 1 || lat_min != int'(D)) begin
         n_fail++;
         $display("FAIL rstmid_latency: got n=%0d lat=%0d expected n=1 lat=%0d",
                  n_out, lat_min, D);
      end
   endtask

   task automatic test_random();
      logic e, fl;
      for (int i = 0; i < 400; i++) begin
         e  = ($urandom % 8) != 0;
         fl = ($urandom % 32) == 0;
         drive(e, fl, 1'($urandom % 2), W'($urandom), 1'(($urandom % 4) != 0));
         #1;
         if (!e || fl) begin
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL rand_gate: got rdy=%b ov=%b expected 0 0 (iter %0d)",
                        in_ready, out_valid, i);
            end
         end
         tick();
      end
      drain("rand");
   endtask

   initial begin
      clear_stats();
      test_reset();
      test_stream();
      test_backpressure();
      test_freeze();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
